// File: rtl/fft_sample_buffer.sv
// Ping-pong dual-bank sample store for the radix-2 FFT: loads a frame, serves butterfly traffic, then unloads the result.
// Define FFT_UNLOAD_BITREV_EN to unload in bit-reversed address order (natural frequency order).
`timescale 1ns/1ps
module fft_sample_buffer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  output logic                    fft_go,
  input  logic                    agu_done,
  input  logic                    roW,
  input  logic [ADDR_WIDTH-1:0]   addr_A_read,
  input  logic [ADDR_WIDTH-1:0]   addr_B_read,
  output logic [2*DATA_WIDTH-1:0] rdata_A,
  output logic [2*DATA_WIDTH-1:0] rdata_B,
  input  logic [ADDR_WIDTH-1:0]   addr_A_write,
  input  logic [ADDR_WIDTH-1:0]   addr_B_write,
  input  logic                    wr_en,
  input  logic [2*DATA_WIDTH-1:0] wdata_A,
  input  logic [2*DATA_WIDTH-1:0] wdata_B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    busy
);

  localparam int N  = 1 << ADDR_WIDTH;
  localparam int WW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(N - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_e;

  logic [WW-1:0] bank0_q [N];
  logic [WW-1:0] bank1_q [N];

  state_e              state_q;
  logic [ADDR_WIDTH:0] load_idx_q;
  logic [ADDR_WIDTH:0] unload_idx_q;
  logic [CW-1:0]       drain_q;
  logic                draining_q;
  logic                first_q;
  logic                res_bank_q;
  logic                in_ready_q;
  logic                fft_go_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [WW-1:0]       out_data_q;
  logic [WW-1:0]       rdata_a_q;
  logic [WW-1:0]       rdata_b_q;

  logic                  load_hs;
  logic                  out_hs;
  logic                  in_compute;
  logic                  ul_bank;
  logic [ADDR_WIDTH-1:0] ul_idx;
  logic [WW-1:0]         out_data_d;

  function automatic logic [ADDR_WIDTH-1:0] unload_addr(input logic [ADDR_WIDTH-1:0] idx);
`ifdef FFT_UNLOAD_BITREV_EN
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = idx[ADDR_WIDTH-1-i];
    return r;
`else
    return idx;
`endif
  endfunction

  assign load_hs    = (state_q == ST_LOAD) && in_valid && in_ready_q;
  assign out_hs     = out_valid_q && out_ready;
  assign in_compute = (state_q == ST_COMPUTE);

  // Next unload word: index 0 when entering UNLOAD, otherwise the word after the current one.
  always_comb begin
    ul_bank = res_bank_q;
    ul_idx  = unload_idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    if (in_compute) begin
      ul_idx = '0;
      if (!draining_q) ul_bank = roW;
    end
    out_data_d = ul_bank ? bank1_q[unload_addr(ul_idx)] : bank0_q[unload_addr(ul_idx)];
  end

  // Bank storage is never reset; B is written last so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      bank0_q[load_idx_q[ADDR_WIDTH-1:0]] <= in_data;
    end else if (in_compute && wr_en) begin
      if (roW) begin
        bank0_q[addr_A_write] <= wdata_A;
        bank0_q[addr_B_write] <= wdata_B;
      end else begin
        bank1_q[addr_A_write] <= wdata_A;
        bank1_q[addr_B_write] <= wdata_B;
      end
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q      <= ST_LOAD;
      load_idx_q   <= '0;
      unload_idx_q <= '0;
      drain_q      <= '0;
      draining_q   <= 1'b0;
      first_q      <= 1'b0;
      res_bank_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      fft_go_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_data_q   <= '0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_hs) begin
            if (load_idx_q == LAST_IDX) begin
              load_idx_q <= '0;
              state_q    <= ST_COMPUTE;
              in_ready_q <= 1'b0;
              fft_go_q   <= 1'b1;
              busy_q     <= 1'b1;
              first_q    <= 1'b1;
              draining_q <= 1'b0;
            end else begin
              load_idx_q <= load_idx_q + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          rdata_a_q <= roW ? bank1_q[addr_A_read] : bank0_q[addr_A_read];
          rdata_b_q <= roW ? bank1_q[addr_B_read] : bank0_q[addr_B_read];
          first_q   <= 1'b0;
          // A done seen on the first cycle is left over from the previous frame.
          if (draining_q ? (drain_q == CW'(1))
                         : (agu_done && !first_q && (DRAIN_CYCLES == 0))) begin
            if (!draining_q) res_bank_q <= roW;
            state_q      <= ST_UNLOAD;
            fft_go_q     <= 1'b0;
            out_valid_q  <= 1'b1;
            out_data_q   <= out_data_d;
            unload_idx_q <= '0;
            draining_q   <= 1'b0;
          end else if (draining_q) begin
            drain_q <= drain_q - CW'(1);
          end else if (agu_done && !first_q) begin
            res_bank_q <= roW;
            draining_q <= 1'b1;
            drain_q    <= CW'(DRAIN_CYCLES);
          end
        end
        ST_UNLOAD: begin
          if (out_hs) begin
            if (unload_idx_q == LAST_IDX) begin
              unload_idx_q <= '0;
              out_valid_q  <= 1'b0;
              state_q      <= ST_LOAD;
              in_ready_q   <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              unload_idx_q <= unload_idx_q + 1'b1;
              out_data_q   <= out_data_d;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign fft_go    = fft_go_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign rdata_A   = rdata_a_q;
  assign rdata_B   = rdata_b_q;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Scoreboard bench for fft_sample_buffer: load, butterfly access, done/drain, backpressured unload and reset abort.
`timescale 1ns/1ps
module tb_fft_sample_buffer;
  localparam int AW = 5;
  localparam int WW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          start;
  logic          in_valid, in_ready;
  logic [WW-1:0] in_data;
  logic          fft_go, agu_done, roW;
  logic [AW-1:0] addr_A_read, addr_B_read, addr_A_write, addr_B_write;
  logic [WW-1:0] rdata_A, rdata_B, wdata_A, wdata_B, out_data;
  logic          wr_en, out_valid, out_ready, busy;

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] m_bank0[N];
  logic [WW-1:0] m_bank1[N];

  fft_sample_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fft_go(fft_go), .agu_done(agu_done), .roW(roW),
    .addr_A_read(addr_A_read), .addr_B_read(addr_B_read), .rdata_A(rdata_A), .rdata_B(rdata_B),
    .addr_A_write(addr_A_write), .addr_B_write(addr_B_write), .wr_en(wr_en),
    .wdata_A(wdata_A), .wdata_B(wdata_B),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int ul_addr(input int k);
`ifdef FFT_UNLOAD_BITREV_EN
    int r = 0;
    for (int b = 0; b < AW; b++) if (k[b]) r |= (1 << (AW - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic load_frame(input logic [WW-1:0] base, input int step, input int count, output int hs);
    int  cyc = 0;
    bit  took;
    hs = 0;
    while (hs < count && cyc < 4 * count + 10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = base + WW'(hs * step);
      took     = in_ready;
      if (took) m_bank0[hs] = in_data;
      @(posedge clk);
      cyc++;
      if (took) hs++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (fft_go !== 1'b0) begin errors++; $display("FAIL reset_fft_go got %0b want 0", fft_go); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (rdata_A !== 32'h0 || rdata_B !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", rdata_A, rdata_B); end
    @(negedge clk) start = 1'b1;
  endtask

  task automatic test_load;
    int hs = 0;
    int cyc = 0;
    bit v = 1'b0;
    bit took;
    while (hs < N && cyc < 200) begin
      @(negedge clk);
      v = !v;
      in_valid = v;
      in_data  = {16'(hs), 16'h0};
      took = in_valid && in_ready;
      if (took) m_bank0[hs] = in_data;
      @(posedge clk);
      cyc++;
      if (took) begin
        hs++;
        if (hs < N) begin
          #1;
          checks++; if (fft_go !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL load_early_go hs=%0d got go=%0b rdy=%0b want 0/1", hs, fft_go, in_ready); end
        end
      end
    end
    #1 in_valid = 1'b0;
    checks++; if (hs != N) begin errors++; $display("FAIL load_handshakes got %0d want %0d", hs, N); end
    checks++; if (fft_go !== 1'b1) begin errors++; $display("FAIL load_fft_go got %0b want 1", fft_go); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL load_after got rdy=%0b busy=%0b want 0/1", in_ready, busy); end
    agu_done = 1'b1;
    @(posedge clk); #1 agu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fft_go !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stale_done got go=%0b ov=%0b want 1/0", fft_go, out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL compute_in_ready got %0b want 0", in_ready); end
  endtask

  task automatic test_butterfly;
    roW = 1'b0; addr_A_read = 5'd3; addr_B_read = 5'd10;
    @(posedge clk); #1;
    checks++; if (rdata_A !== 32'h0003_0000) begin errors++; $display("FAIL bf_read_A got %h want 00030000", rdata_A); end
    checks++; if (rdata_B !== m_bank0[10]) begin errors++; $display("FAIL bf_read_B got %h want %h", rdata_B, m_bank0[10]); end
    wr_en = 1'b1; addr_A_write = 5'd7; addr_B_write = 5'd7; wdata_A = 32'd1; wdata_B = 32'd2;
    @(posedge clk); #1;
    m_bank1[7] = 32'd2;
    wr_en = 1'b0; roW = 1'b1; addr_A_read = 5'd7;
    @(posedge clk); #1;
    checks++; if (rdata_A !== 32'd2) begin errors++; $display("FAIL bf_b_wins got %h want 00000002", rdata_A); end
    for (int i = 0; i < 16; i++) begin
      roW = 1'b0; wr_en = 1'b1;
      addr_A_write = AW'(i); addr_B_write = AW'(i + 16);
      wdata_A = 32'(i); wdata_B = 32'(i + 16);
      m_bank1[i] = 32'(i); m_bank1[i + 16] = 32'(i + 16);
      @(posedge clk); #1;
    end
    wr_en = 1'b0; roW = 1'b1; addr_A_read = 5'd5; addr_B_read = 5'd21;
    @(posedge clk); #1;
    checks++; if (rdata_A !== 32'd5 || rdata_B !== 32'd21) begin errors++; $display("FAIL bf_fill got %h/%h want 5/21", rdata_A, rdata_B); end
  endtask

  task automatic test_done_drain;
    roW = 1'b1; agu_done = 1'b1; wr_en = 1'b1;
    addr_A_write = 5'd1; addr_B_write = 5'd2; wdata_A = 32'hDEAD_0001; wdata_B = 32'hDEAD_0002;
    m_bank0[1] = wdata_A; m_bank0[2] = wdata_B;
    @(posedge clk); #1;
    checks++; if (fft_go !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_c1 got go=%0b ov=%0b want 1/0", fft_go, out_valid); end
    agu_done = 1'b0; roW = 1'b1;
    addr_A_write = 5'd3; addr_B_write = 5'd4; wdata_A = 32'hDEAD_0003; wdata_B = 32'hDEAD_0004;
    m_bank0[3] = wdata_A; m_bank0[4] = wdata_B;
    @(posedge clk); #1;
    checks++; if (fft_go !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_c2 got go=%0b ov=%0b want 1/0", fft_go, out_valid); end
    roW = 1'b0;
    addr_A_write = 5'd30; addr_B_write = 5'd31; wdata_A = 32'hC0DE_0001; wdata_B = 32'hC0DE_0002;
    m_bank1[30] = wdata_A; m_bank1[31] = wdata_B;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (fft_go !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL unload_entry got go=%0b ov=%0b want 0/1", fft_go, out_valid); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL unload_busy got busy=%0b rdy=%0b want 1/0", busy, in_ready); end
    for (int k = 0; k < N; k++) exp_q.push_back(m_bank1[ul_addr(k)]);
  endtask

  task automatic test_backpressure;
    int got = 0;
    int cyc = 0;
    int stall = 0;
    logic [WW-1:0] first4[4];
    logic [WW-1:0] e;
`ifdef FFT_UNLOAD_BITREV_EN
    first4[0] = 32'd0; first4[1] = 32'd16; first4[2] = 32'd8; first4[3] = 32'd24;
`else
    first4[0] = 32'd0; first4[1] = 32'd1; first4[2] = 32'd2; first4[3] = 32'd3;
`endif
    while (got < N && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = !(got == 5 && stall < 3);
      checks++; if (out_valid === 1'b1 && in_ready !== 1'b0) begin errors++; $display("FAIL unload_overlap got rdy=%0b want 0", in_ready); end
      if (!out_ready) begin
        stall++;
        e = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL bp_hold got ov=%0b data=%h want 1/%h", out_valid, out_data, e); end
      end else if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_extra got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e) begin errors++; $display("FAIL bp_word%0d got %h want %h", got, out_data, e); end
          if (got < 4) begin
            checks++; if (out_data !== first4[got]) begin errors++; $display("FAIL order_word%0d got %h want %h", got, out_data, first4[got]); end
          end
        end
        got++;
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b0;
    checks++; if (got != N || exp_q.size() != 0) begin errors++; $display("FAIL bp_count got %0d left %0d want %0d left 0", got, exp_q.size(), N); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_last_valid got %0b want 0", out_valid); end
    for (int c = 0; c < 3 && in_ready !== 1'b1; c++) begin @(posedge clk); #1; end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reload_ready got rdy=%0b busy=%0b want 1/0", in_ready, busy); end
  endtask

  task automatic test_reset_mid_unload;
    int hs;
    load_frame(32'h1000_0000, 1, N, hs);
    checks++; if (hs != N) begin errors++; $display("FAIL rst_load got %0d want %0d", hs, N); end
    @(posedge clk); #1 agu_done = 1'b1; roW = 1'b1;
    @(posedge clk); #1 agu_done = 1'b0;
    for (int c = 0; c < 10 && out_valid !== 1'b1; c++) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b want 1", out_valid); end
    #2 start = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_abort got ov=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    checks++; if (fft_go !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rst_abort2 got go=%0b busy=%0b data=%h want 0/0/0", fft_go, busy, out_data); end
    @(negedge clk) start = 1'b1;
  endtask

  task automatic test_back_to_back;
    int hs;
    int got = 0;
    int cyc = 0;
    logic [WW-1:0] e;
    load_frame(32'hEE00_0000, 1, 10, hs);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    load_frame(32'h5A00_0000, 3, N, hs);
    checks++; if (hs != N || fft_go !== 1'b1) begin errors++; $display("FAIL b2b_load got hs=%0d go=%0b want %0d/1", hs, fft_go, N); end
    roW = 1'b0; addr_A_read = 5'd0; addr_B_read = 5'd31;
    @(posedge clk); #1;
    checks++; if (rdata_A !== 32'h5A00_0000) begin errors++; $display("FAIL b2b_idx0 got %h want 5a000000", rdata_A); end
    checks++; if (rdata_B !== 32'h5A00_005D) begin errors++; $display("FAIL b2b_idx31 got %h want 5a00005d", rdata_B); end
    agu_done = 1'b1;
    for (int k = 0; k < N; k++) exp_q.push_back(m_bank0[ul_addr(k)]);
    @(posedge clk); #1 agu_done = 1'b0;
    for (int c = 0; c < 10 && out_valid !== 1'b1; c++) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    while (got < N && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (out_data !== e) begin errors++; $display("FAIL b2b_word%0d got %h want %h", got, out_data, e); end
        got++;
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b0;
    checks++; if (got != N || cyc != N) begin errors++; $display("FAIL b2b_throughput got %0d words in %0d cycles want %0d in %0d", got, cyc, N, N); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_last_valid got %0b want 0", out_valid); end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = '0; agu_done = 1'b0; roW = 1'b0;
    addr_A_read = '0; addr_B_read = '0; addr_A_write = '0; addr_B_write = '0;
    wr_en = 1'b0; wdata_A = '0; wdata_B = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin m_bank0[i] = 'x; m_bank1[i] = 'x; end
    test_reset();
    test_load();
    test_butterfly();
    test_done_drain();
    test_backpressure();
    test_reset_mid_unload();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
